// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS core and its program loader
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    localparam int LOAD_LEN_W = 16;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles big-endian bytes into 32-bit words with a one-cycle word_valid pulse
module byte_packer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  cnt_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        valid_q, valid_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        if (en_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[23:0], byte_i};
            valid_d = (cnt_q == 2'd3);
        end
    end

    // The shift register doubles as the word output: the next word's first byte
    // only lands on the edge that ends the write cycle, so the data is stable then.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign word_o       = shift_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed program into instruction memory while holding the core
module program_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int LW = LOAD_LEN_W + 1;
    localparam logic [LW-1:0] CAP = LW'(2 ** ADDR_W);

    loader_state_t     state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [LW-1:0]     n_q;
    logic [LW-1:0]     widx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LW-1:0]     len_n;
    logic [1:0]        byte_cnt;
    logic              xfer;
    logic              word_last;

    assign in_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
    assign xfer      = in_valid && in_ready;
    assign len_n     = {1'b0, len_hi_q, in_byte};
    assign word_last = (state_q == DATA) && xfer && (byte_cnt == 2'd3);

    byte_packer u_packer (
        .clk_i        (clk),
        .reset_i      (reset),
        .en_i         ((state_q == DATA) && xfer),
        .byte_i       (in_byte),
        .cnt_o        (byte_cnt),
        .word_o       (imem_wdata),
        .word_valid_o (imem_we)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = LEN_HI;
            LEN_HI: if (xfer) state_d = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_n == '0)     state_d = DONE;
                    else if (len_n > CAP) state_d = ERR;
                    else                  state_d = DATA;
                end
            end
            DATA:   if (word_last && (widx_q == n_q - LW'(1))) state_d = DONE;
            DONE:   if (start) state_d = LEN_HI;
            ERR:    if (start) state_d = LEN_HI;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_hi_q <= '0;
            n_q      <= '0;
            widx_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == LEN_HI) && xfer) len_hi_q <= in_byte;
            if ((state_q == LEN_LO) && xfer) begin
                n_q    <= len_n;
                widx_q <= '0;
            end
            if (word_last) begin
                addr_q <= widx_q[ADDR_W-1:0];
                widx_q <= widx_q + LW'(1);
            end
        end
    end

    // DONE is entered together with the final write strobe; release the core one cycle later.
    assign done      = (state_q == DONE) && !imem_we;
    assign cpu_hold  = !done;
    assign error     = (state_q == ERR);
    assign imem_addr = addr_q;

endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream (length header followed by big-endian instruction words) over a valid/ready handshake. It assembles the bytes into 32-bit words and writes them to consecutive instruction-memory word addresses. It holds the core stalled until the whole program is in memory.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a new load
- in_valid  in  1  in_byte holds a valid byte
- in_byte  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  stalls the core (PC frozen, no register or memory writes)
- done  out  1  level; program fully written
- error  out  1  level; header length exceeded capacity

## Operation
- Stream format:
  - Byte 0 is the length high byte, byte 1 the length low byte. Together they give N, an unsigned 16-bit word count.
  - The header is followed by 4*N data bytes, most-significant byte of each word first.
- Byte transfer: a byte transfers on a cycle with in_valid && in_ready. in_ready depends only on state, never on in_valid.
- States:
  - IDLE: in_ready=0, cpu_hold=1. start -> LEN_HI.
  - LEN_HI: in_ready=1. Transfer -> LEN_LO.
  - LEN_LO: in_ready=1. On transfer, N is known:
    - N=0 -> DONE.
    - N > 2**ADDR_W -> ERR.
    - Otherwise -> DATA.
  - DATA: in_ready=1.
    - A 2-bit byte counter selects the shift position.
    - On the 4th byte of a word, the word is registered and imem_we is raised for the next cycle.
    - The word counter increments after each write.
    - After word N-1 is written -> DONE.
  - DONE: in_ready=0, cpu_hold=0, done=1. start -> LEN_HI.
  - ERR: in_ready=0, cpu_hold=1, error=1. start -> LEN_HI.
- start is ignored in LEN_HI, LEN_LO and DATA. Leaving DONE or ERR on start clears done/error and raises cpu_hold in the same transition.
- imem_addr = word index, 0..N-1, truncated to ADDR_W bits. N = 2**ADDR_W is legal and ends at address 2**ADDR_W-1; it never wraps to 0 for a write.
- Bytes held on in_valid while in_ready=0 are not consumed.
- The header width is fixed at 16 bits regardless of ADDR_W. The comparison with 2**ADDR_W uses a 17-bit compare.

## Timing
- Reset values:
  - State = IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, done=0, error=0.
  - Byte counter and word counter = 0.
- Reset mid-load: the partial word is discarded and nothing further is written; the memory contents already written are left untouched.
- Write latency: imem_we is high in the cycle after the 4th byte transfer of a word, with imem_addr and imem_wdata stable in that same cycle.
- Throughput: one byte per cycle sustained. A new word's first byte may transfer in the same cycle as the previous word's imem_we.
- Completion: done rises and cpu_hold falls in the cycle after the final imem_we. The core's first fetch therefore sees all words written.
- Header latency: LEN_LO -> DONE (N=0) or -> ERR takes effect on the next edge after the low-byte transfer.
- in_valid gaps of any length inside a word or the header are tolerated; partial state is retained.

## Structure
- The shared package (mips_pkg) holds:
  - The loader_state_t enum: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
  - The header width constant LOAD_LEN_W=16.
- The byte-to-word assembler (2-bit counter plus 32-bit shift register plus word_valid pulse) is a natural sub-module: byte_packer.
- The top-level MIPS wrapper instantiates program_loader next to the instruction memory, ORs imem_we into its write port, and gates PC/regfile/dmem write enables with cpu_hold.

## Test plan
- Basic load, ADDR_W=8: after reset, pulse start and stream 00 02 20 11 00 05 20 12 00 07. Required: imem_we in exactly 2 cycles, with (addr 0, 0x20110005) then (addr 1, 0x20120007). done=1 and cpu_hold=0 one cycle after the second write.
- Zero length: start, then 00 00. Required: no imem_we; done=1 on the edge after the second byte.
- Overflow, ADDR_W=4: header 00 11 (N=17). Required: error=1, in_ready=0, cpu_hold stays 1, no writes. A later start plus header 00 01 and word DEADBEEF writes 0xDEADBEEF at addr 0 and clears error.
- Backpressure and gaps: same stream as the basic load with in_valid toggling 1,0,0,1 per cycle. Required: identical writes and data; in_ready stays 1 throughout DATA.
- Reset mid-word: after header 00 01 and bytes AA BB, assert reset for 1 cycle. Required: no imem_we, cpu_hold=1, state IDLE. Bytes offered afterwards are not accepted (in_ready=0) until start.
- Full capacity, ADDR_W=4: N=16 with word k = k. Required: 16 writes at addresses 0..15 in order, the last at addr 15 with data 0x0000000F, then done=1.
